// File: rtl/priority_pkg.sv
// Shared definitions for the priority decoder / hold block.
//   state_t        : FSM encoding (IDLE, GRANT)
//   N_DEF, OUT_W   : default index width and matching one-hot width
//   CNT_W          : hold counter width
//   idx_to_onehot  : reference index-to-one-hot expansion at the default width
package priority_pkg;

  localparam int N_DEF = 2;
  localparam int OUT_W = 2 ** N_DEF;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [OUT_W-1:0] idx_to_onehot(input logic [N_DEF-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter used to time a grant hold.
//   clk, rst    : clock, synchronous active-high reset (clears to 0)
//   load        : load load_value this edge (takes priority over counting)
//   load_value  : value to load
//   value       : current count
//   zero        : high when value == 0; the counter parks at zero
module hold_counter
  import priority_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;

  always_comb begin
    value_next = value_reg;
    if (load) begin
      value_next = load_value;
    end else if (value_reg != '0) begin
      value_next = value_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);

endmodule

// File: rtl/priority_decoder_hold.sv
// Index-to-one-hot grant decoder with programmable hold time.
//   clk, rst     : clock, synchronous active-high reset
//   in_code      : encoded index to decode
//   in_valid     : in_code valid this cycle
//   in_ready     : block accepts in_code this cycle
//   onehot_out   : registered one-hot grant
//   grant_active : high while a hold is in progress
//   grant_done   : pulse on the final hold cycle
//   last_code    : index of the most recently accepted code
module priority_decoder_hold
  import priority_pkg::*;
#(
  parameter int N           = 2,
  parameter int HOLD_CYCLES = 3,
  parameter int STICKY      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_code,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2**N-1:0] onehot_out,
  output logic            grant_active,
  output logic            grant_done,
  output logic [N-1:0]    last_code
);

  localparam int OW = 2 ** N;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [OW-1:0]    onehot_reg;
  logic [OW-1:0]    onehot_next;
  logic [N-1:0]     last_code_reg;
  logic [N-1:0]     last_code_next;
  logic [OW-1:0]    decoded;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;
  logic             cnt_load;
  logic             accept;

  // Compare-per-line decode; exactly one bit matches any in_code value.
  genvar gi;
  generate
    for (gi = 0; gi < OW; gi++) begin : g_decode
      assign decoded[gi] = (in_code == N'(gi));
    end
  endgenerate

  hold_counter #(
    .W(CNT_W)
  ) u_hold_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(LOAD_VAL),
    .value     (cnt_value),
    .zero      (cnt_zero)
  );

  // The final hold cycle is ready so a waiting code reloads with no gap.
  // In IDLE the counter is parked at zero, so cnt_zero alone would do,
  // but the state term keeps the intent explicit.
  assign in_ready = ~rst & ((state_reg == IDLE) | cnt_zero);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_next     = state_reg;
    onehot_next    = onehot_reg;
    last_code_next = last_code_reg;
    cnt_load       = 1'b0;
    if (accept) begin
      state_next     = GRANT;
      onehot_next    = decoded;
      last_code_next = in_code;
      cnt_load       = 1'b1;
    end else if ((state_reg == GRANT) && cnt_zero) begin
      state_next = IDLE;
      if (STICKY == 0) begin
        onehot_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      onehot_reg    <= '0;
      last_code_reg <= '0;
    end else begin
      state_reg     <= state_next;
      onehot_reg    <= onehot_next;
      last_code_reg <= last_code_next;
    end
  end

  assign onehot_out   = onehot_reg;
  assign grant_active = (state_reg == GRANT);
  assign grant_done   = (state_reg == GRANT) && cnt_zero;
  assign last_code    = last_code_reg;

endmodule

// File: tb/tb_priority_decoder_hold.sv
// Self-checking bench for priority_decoder_hold. Three instances share clk:
//   0: HOLD_CYCLES=3 STICKY=0, 1: HOLD_CYCLES=3 STICKY=1, 2: HOLD_CYCLES=1 STICKY=0.
module tb_priority_decoder_hold;
  import priority_pkg::*;

  typedef struct packed {
    logic [3:0] oh;
    logic       act;
    logic       done;
    logic       rdy;
    logic [1:0] last;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic       v;
    logic [1:0] c;
    exp_t       e;
  } row_t;

  logic       clk;
  logic       rst_v   [3];
  logic       valid_v [3];
  logic [1:0] code_v  [3];
  logic       ready_v [3];
  logic [3:0] oh_v    [3];
  logic       act_v   [3];
  logic       done_v  [3];
  logic [1:0] last_v  [3];

  int   total;
  int   bad;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  priority_decoder_hold #(.N(2), .HOLD_CYCLES(3), .STICKY(0)) u_norm (
    .clk(clk), .rst(rst_v[0]), .in_code(code_v[0]), .in_valid(valid_v[0]),
    .in_ready(ready_v[0]), .onehot_out(oh_v[0]), .grant_active(act_v[0]),
    .grant_done(done_v[0]), .last_code(last_v[0]));

  priority_decoder_hold #(.N(2), .HOLD_CYCLES(3), .STICKY(1)) u_sticky (
    .clk(clk), .rst(rst_v[1]), .in_code(code_v[1]), .in_valid(valid_v[1]),
    .in_ready(ready_v[1]), .onehot_out(oh_v[1]), .grant_active(act_v[1]),
    .grant_done(done_v[1]), .last_code(last_v[1]));

  priority_decoder_hold #(.N(2), .HOLD_CYCLES(1), .STICKY(0)) u_fast (
    .clk(clk), .rst(rst_v[2]), .in_code(code_v[2]), .in_valid(valid_v[2]),
    .in_ready(ready_v[2]), .onehot_out(oh_v[2]), .grant_active(act_v[2]),
    .grant_done(done_v[2]), .last_code(last_v[2]));

  function automatic row_t mk(logic r, logic v, logic [1:0] c, logic [3:0] oh,
                              logic act, logic done, logic rdy, logic [1:0] last);
    row_t x;
    x.r = r; x.v = v; x.c = c;
    x.e.oh = oh; x.e.act = act; x.e.done = done; x.e.rdy = rdy; x.e.last = last;
    return x;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    exp_t e, o;
    rows.push_back(mk(1, 1, 2'b10, 4'b0000, 0, 0, 0, 2'b00));
    rows.push_back(mk(1, 1, 2'b10, 4'b0000, 0, 0, 0, 2'b00));
    rows.push_back(mk(0, 1, 2'b10, 4'b0100, 1, 0, 0, 2'b10));
    rows.push_back(mk(0, 0, 2'b00, 4'b0100, 1, 0, 0, 2'b10));
    rows.push_back(mk(0, 0, 2'b00, 4'b0100, 1, 1, 1, 2'b10));
    rows.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b10));
    foreach (rows[i]) begin
      rst_v[0] = rows[i].r; valid_v[0] = rows[i].v; code_v[0] = rows[i].c;
      sb.push_back(rows[i].e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = {oh_v[0], act_v[0], done_v[0], ready_v[0], last_v[0]};
      total++;
      $display("reset step %0d oh=%b act=%b done=%b rdy=%b last=%b", i, o.oh, o.act, o.done, o.rdy, o.last);
      if (o !== e) begin
        bad++;
        $display("FAIL reset step %0d got oh/act/done/rdy/last=%b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    exp_t e, o;
    rows.push_back(mk(0, 1, 2'b01, 4'b0010, 1, 0, 0, 2'b01));
    rows.push_back(mk(0, 1, 2'b11, 4'b0010, 1, 0, 0, 2'b01));
    rows.push_back(mk(0, 1, 2'b11, 4'b0010, 1, 1, 1, 2'b01));
    rows.push_back(mk(0, 1, 2'b11, 4'b1000, 1, 0, 0, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b1000, 1, 0, 0, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b1000, 1, 1, 1, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b11));
    foreach (rows[i]) begin
      rst_v[0] = rows[i].r; valid_v[0] = rows[i].v; code_v[0] = rows[i].c;
      sb.push_back(rows[i].e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = {oh_v[0], act_v[0], done_v[0], ready_v[0], last_v[0]};
      total++;
      $display("stall step %0d oh=%b act=%b done=%b rdy=%b last=%b", i, o.oh, o.act, o.done, o.rdy, o.last);
      if (o !== e) begin
        bad++;
        $display("FAIL stall step %0d got oh/act/done/rdy/last=%b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    row_t rows[$];
    exp_t e, o;
    rows.push_back(mk(0, 1, 2'b10, 4'b0100, 1, 0, 0, 2'b10));
    rows.push_back(mk(0, 0, 2'b00, 4'b0100, 1, 0, 0, 2'b10));
    rows.push_back(mk(1, 0, 2'b00, 4'b0000, 0, 0, 0, 2'b00));
    rows.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b00));
    rows.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b00));
    foreach (rows[i]) begin
      rst_v[0] = rows[i].r; valid_v[0] = rows[i].v; code_v[0] = rows[i].c;
      sb.push_back(rows[i].e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = {oh_v[0], act_v[0], done_v[0], ready_v[0], last_v[0]};
      total++;
      $display("midreset step %0d oh=%b act=%b done=%b rdy=%b last=%b", i, o.oh, o.act, o.done, o.rdy, o.last);
      if (o !== e) begin
        bad++;
        $display("FAIL midreset step %0d got oh/act/done/rdy/last=%b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_sticky();
    row_t rows[$];
    exp_t e, o;
    rows.push_back(mk(0, 1, 2'b11, 4'b1000, 1, 0, 0, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b1000, 1, 0, 0, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b1000, 1, 1, 1, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b1000, 0, 0, 1, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b1000, 0, 0, 1, 2'b11));
    rows.push_back(mk(1, 0, 2'b00, 4'b0000, 0, 0, 0, 2'b00));
    rows.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b00));
    foreach (rows[i]) begin
      rst_v[1] = rows[i].r; valid_v[1] = rows[i].v; code_v[1] = rows[i].c;
      sb.push_back(rows[i].e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = {oh_v[1], act_v[1], done_v[1], ready_v[1], last_v[1]};
      total++;
      $display("sticky step %0d oh=%b act=%b done=%b rdy=%b last=%b", i, o.oh, o.act, o.done, o.rdy, o.last);
      if (o !== e) begin
        bad++;
        $display("FAIL sticky step %0d got oh/act/done/rdy/last=%b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e, o;
    rows.push_back(mk(0, 1, 2'b00, 4'b0001, 1, 1, 1, 2'b00));
    rows.push_back(mk(0, 1, 2'b01, 4'b0010, 1, 1, 1, 2'b01));
    rows.push_back(mk(0, 1, 2'b10, 4'b0100, 1, 1, 1, 2'b10));
    rows.push_back(mk(0, 1, 2'b11, 4'b1000, 1, 1, 1, 2'b11));
    rows.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 0, 1, 2'b11));
    foreach (rows[i]) begin
      rst_v[2] = rows[i].r; valid_v[2] = rows[i].v; code_v[2] = rows[i].c;
      sb.push_back(rows[i].e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = {oh_v[2], act_v[2], done_v[2], ready_v[2], last_v[2]};
      total++;
      $display("b2b step %0d oh=%b act=%b done=%b rdy=%b last=%b", i, o.oh, o.act, o.done, o.rdy, o.last);
      if (o !== e) begin
        bad++;
        $display("FAIL b2b step %0d got oh/act/done/rdy/last=%b expected %b", i, o, e);
      end
    end
  endtask

  // Random valid gaps on instance 0, checked against a behavioural model.
  task automatic test_sweep();
    exp_t       e, o;
    logic       m_grant;
    int         m_cnt;
    logic [3:0] m_oh;
    logic [1:0] m_last;
    logic       m_ready;
    logic       v;
    logic [1:0] c;
    m_grant = 1'b0; m_cnt = 0; m_oh = 4'b0000; m_last = 2'b00;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 2) != 0);
      c = 2'($urandom_range(0, 3));
      rst_v[0] = 1'b0; valid_v[0] = v; code_v[0] = c;
      m_ready = !m_grant || (m_cnt == 0);
      if (v && m_ready) begin
        m_grant = 1'b1; m_cnt = 2; m_oh = idx_to_onehot(c); m_last = c;
      end else if (m_grant && m_cnt == 0) begin
        m_grant = 1'b0; m_oh = 4'b0000;
      end else if (m_grant) begin
        m_cnt--;
      end
      e.oh   = m_oh;
      e.act  = m_grant;
      e.done = m_grant && (m_cnt == 0);
      e.rdy  = !m_grant || (m_cnt == 0);
      e.last = m_last;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      o = {oh_v[0], act_v[0], done_v[0], ready_v[0], last_v[0]};
      total++;
      $display("sweep step %0d v=%b c=%b oh=%b act=%b done=%b rdy=%b last=%b", i, v, c, o.oh, o.act, o.done, o.rdy, o.last);
      if (o !== e) begin
        bad++;
        $display("FAIL sweep step %0d got oh/act/done/rdy/last=%b expected %b", i, o, e);
      end
      total++;
      if ($countones(oh_v[0]) > 1) begin
        bad++;
        $display("FAIL sweep onehot step %0d got %b expected at most one bit", i, oh_v[0]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; valid_v[k] = 1'b0; code_v[k] = 2'b00;
    end
    test_reset();
    test_stall();
    test_mid_reset();
    test_sweep();
    test_sticky();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/priority_decoder_hold.md
Name: priority_decoder_hold

Overview:
- Inverse of the 4-to-2 priority encoder: takes an encoded index plus a valid strobe and drives a registered one-hot grant vector.
- Each grant is held for a programmable number of cycles, then released.
- Sits on the grant side of request/grant paths; the encoder's index output feeds it to re-expand the winning line.
- Valid/ready handshake so upstream stalls while a grant is held.

Parameters:
- N, 2, encoded index width; one-hot output width is 2**N (default 4).
- HOLD_CYCLES, 3, cycles each accepted grant stays asserted; legal range 1..255.
- STICKY, 0, 1 = one-hot output keeps the last grant after the hold expires; 0 = output returns to all-zero.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_code  input  N  encoded index to decode.
- in_valid  input  1  in_code valid this cycle.
- in_ready  output  1  block accepts in_code this cycle.
- onehot_out  output  2**N  registered one-hot grant.
- grant_active  output  1  high while a hold is in progress.
- grant_done  output  1  one-cycle pulse on the final hold cycle.
- last_code  output  N  index of the most recently accepted code.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE, onehot_out=0, grant_active=0, grant_done=0, last_code=0, hold counter=0.
  - in_ready=0 while rst is high.
- States:
  - IDLE: no grant in progress. in_ready=1.
  - GRANT: in_ready=1 only when cnt==0 (final hold cycle), otherwise 0.
- Accept: an accept occurs on an edge where in_valid && in_ready. On that edge:
  - onehot_out <= 1<<in_code.
  - last_code <= in_code.
  - cnt <= HOLD_CYCLES-1.
  - state <= GRANT.
  - Latency: one cycle; onehot_out is valid the cycle after the accept edge.
- GRANT with cnt>0: cnt decrements each cycle; onehot_out is stable; in_code and in_valid are ignored.
- GRANT with cnt==0 (final cycle): grant_done=1 (combinational from state and cnt).
  - With accept: reload the new grant directly. No gap cycle; grant_active stays 1.
  - Without accept: state <= IDLE. onehot_out <= 0 if STICKY=0, else it holds its value.
- grant_active=1 exactly in GRANT, so it is high for HOLD_CYCLES cycles per grant.
- HOLD_CYCLES=1:
  - Every grant lasts one cycle and grant_done is high on every grant cycle.
  - in_ready stays high, giving full throughput with back-to-back accepts.
- in_valid in IDLE with no grant pending: it is accepted the same edge.
- in_valid held high continuously: grants chain back-to-back. Each accept samples in_code on that edge.
- Reset mid-grant: the next edge forces all reset values, including onehot_out=0 even with STICKY=1. The pending grant is discarded and grant_done does not pulse.
- onehot_out never has more than one bit set. It is never X after the first edge with rst=1.
- cnt width: 8 bits. Behaviour for HOLD_CYCLES outside 1..255 is illegal.

Decomposition:
- Shared package priority_pkg:
  - state enum (IDLE, GRANT).
  - localparam for one-hot width, OUT_W = 2**N.
  - CNT_W=8.
  - Helper function idx_to_onehot(code), reused by the encoder bench as a golden model.
- One sub-module, hold_counter: loadable down-counter with load, value, and a zero flag. The FSM and decode stay in priority_decoder_hold.

Test Plan:
- Reset: rst=1 for 2 cycles, then in_code=2'b10, in_valid=1 → during reset onehot_out=0000, last_code=00, in_ready=0. Next edge accepts: onehot_out=0100 for 3 cycles, grant_done high on the 3rd, then 0000.
- Stall: accept code 01; present code 11 with valid held high → in_ready low for 2 cycles. On the 3rd cycle code 11 is accepted. onehot_out goes 0010,0010,0010,1000 with no zero gap.
- STICKY=1: accept code 11, then in_valid=0 → onehot_out stays 1000 after the hold. grant_active drops to 0. last_code=11.
- HOLD_CYCLES=1: codes 00,01,10,11 back-to-back → onehot_out 0001,0010,0100,1000 on consecutive cycles. in_ready constantly 1. grant_done high on 4 consecutive cycles.
- Reset mid-grant: accept code 10, assert rst on hold cycle 2 → next edge onehot_out=0000, grant_active=0, no grant_done pulse. After reset release with valid low, outputs stay idle.
- Exhaustive sweep: all 4 codes with random in_valid gaps → onehot_out always matches idx_to_onehot(last_code) while grant_active=1, and has at most one bit set every cycle.
